// File: rtl/hetero_pkg.sv
// Shared types and constants for the heterogeneous task dispatcher.
package hetero_pkg;

  typedef enum logic {
    CLS_SCALAR = 1'b0,
    CLS_VECTOR = 1'b1
  } task_class_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } dispatch_state_e;

  localparam logic [1:0] LOAD_IDLE = 2'd0;
  localparam logic [1:0] LOAD_LOW  = 2'd1;
  localparam logic [1:0] LOAD_MID  = 2'd2;
  localparam logic [1:0] LOAD_FULL = 2'd3;

endpackage

// File: rtl/htd_task_fifo.sv
// Synchronous FIFO of {class, payload} entries with show-ahead head and occupancy count.
module htd_task_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/hetero_task_dispatcher.sv
// FIFO-buffered task dispatcher: offers the head task to an idle core of matching class, round-robin.
// Optional head-of-line aging (class waiver after AGE_LIMIT blocked cycles) is enabled by HTD_AGING_EN.
module hetero_task_dispatcher
  import hetero_pkg::*;
#(
  parameter int                   NUM_CORES  = 4,
  parameter int                   TASK_W     = 32,
  parameter int                   DEPTH      = 8,
  parameter logic [NUM_CORES-1:0] CORE_CLASS = 4'b1100,
  parameter int                   AGE_LIMIT  = 16,
  localparam int                  LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 task_valid,
  output logic                 task_ready,
  input  logic [TASK_W-1:0]    task_data,
  input  logic                 task_class,
  output logic [NUM_CORES-1:0] disp_valid,
  output logic [TASK_W-1:0]    disp_data,
  input  logic [NUM_CORES-1:0] disp_ready,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [NUM_CORES-1:0] core_busy,
  output logic [LVL_W-1:0]     queue_level,
  output logic [1:0]           load_level,
  output dispatch_state_e      fsm_state
);

  localparam int PTR_W = $clog2(NUM_CORES);

  // Handshake: a task moves from producer to FIFO when task_valid && task_ready; an offer
  // completes when disp_valid[sel] && disp_ready[sel]; disp_valid/disp_data never change
  // while an offer is pending.

  if (NUM_CORES < 2 || NUM_CORES > 16 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AGE_LIMIT < 1)
  begin : g_bad_params
    $error("hetero_task_dispatcher: illegal parameter set");
  end

  logic [TASK_W:0]      head_entry;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 go;
  logic                 fresh;
  dispatch_state_e      state;
  dispatch_state_e      state_next;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     sel;
  logic [PTR_W-1:0]     sel_next;
  logic [PTR_W:0]       rr_idx;
  logic [NUM_CORES-1:0] class_match;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] set_mask;
  logic [1:0]           load_next;

  htd_task_fifo #(
    .W     (TASK_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (task_valid),
    .wdata ({task_class, task_data}),
    .pop   (pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (queue_level)
  );

  assign task_ready = !fifo_full;
  assign fsm_state  = state;

  always_comb begin
    class_match = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      class_match[i] = (CORE_CLASS[i] == head_entry[TASK_W]);
    end
  end

`ifdef HTD_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] age_cnt;
  logic             aged;

  assign aged     = (age_cnt == AGE_W'(AGE_LIMIT));
  assign eligible = aged ? ~core_busy : (~core_busy & class_match);

  // Counts only while the head is blocked by class alone; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_cnt <= '0;
    end else if (pop) begin
      age_cnt <= '0;
    end else if (state == S_IDLE && !fifo_empty && !aged &&
                 !(|(~core_busy & class_match)) && |(~core_busy)) begin
      age_cnt <= age_cnt + AGE_W'(1);
    end
  end
`else
  assign eligible = ~core_busy & class_match;
`endif

  // Lowest rotation offset from rr_ptr wins; descending scan lets the last hit be the nearest.
  always_comb begin
    sel_next = rr_ptr;
    rr_idx   = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      rr_idx = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (rr_idx >= (PTR_W + 1)'(NUM_CORES)) rr_idx = rr_idx - (PTR_W + 1)'(NUM_CORES);
      if (eligible[rr_idx[PTR_W-1:0]]) sel_next = rr_idx[PTR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    go         = 1'b0;
    pop        = 1'b0;
    set_mask   = '0;
    disp_valid = '0;
    case (state)
      S_IDLE: begin
        // A just-written head gets one settle cycle before it can be offered.
        if (!fifo_empty && !fresh && |eligible) begin
          go         = 1'b1;
          state_next = S_OFFER;
        end
      end
      S_OFFER: begin
        disp_valid[sel] = 1'b1;
        if (disp_ready[sel]) begin
          pop           = 1'b1;
          set_mask[sel] = 1'b1;
          state_next    = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    load_next = LOAD_IDLE;
    if (fifo_full)                                     load_next = LOAD_FULL;
    else if (queue_level >= LVL_W'(DEPTH / 2))         load_next = LOAD_MID;
    else if (queue_level != '0 || |core_busy)          load_next = LOAD_LOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= '0;
      rr_ptr     <= '0;
      disp_data  <= '0;
      core_busy  <= '0;
      fresh      <= 1'b0;
      load_level <= LOAD_IDLE;
    end else begin
      fresh <= task_valid && task_ready && fifo_empty;
      if (go) begin
        sel       <= sel_next;
        disp_data <= head_entry[TASK_W-1:0];
      end
      if (pop) rr_ptr <= (sel == PTR_W'(NUM_CORES - 1)) ? '0 : sel + PTR_W'(1);
      core_busy  <= (core_busy & ~core_done) | set_mask;
      load_level <= load_next;
    end
  end

endmodule

// File: tb/tb_hetero_task_dispatcher.sv
// Directed self-checking bench for hetero_task_dispatcher (default parameters, 4 cores, depth 8).
module tb_hetero_task_dispatcher;
  import hetero_pkg::*;

  localparam int NC        = 4;
  localparam int TW        = 32;
  localparam int DEPTH     = 8;
  localparam int AGE_LIMIT = 16;
  localparam int LW        = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            task_valid = 1'b0;
  logic            task_ready;
  logic [TW-1:0]   task_data = '0;
  logic            task_class = 1'b0;
  logic [NC-1:0]   disp_valid;
  logic [TW-1:0]   disp_data;
  logic [NC-1:0]   disp_ready = '0;
  logic [NC-1:0]   core_done = '0;
  logic [NC-1:0]   core_busy;
  logic [LW-1:0]   queue_level;
  logic [1:0]      load_level;
  dispatch_state_e fsm_state;

  int checks = 0;
  int failures = 0;
  logic [TW-1:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  hetero_task_dispatcher #(
    .NUM_CORES  (NC),
    .TASK_W     (TW),
    .DEPTH      (DEPTH),
    .CORE_CLASS (4'b1100),
    .AGE_LIMIT  (AGE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .task_valid  (task_valid),
    .task_ready  (task_ready),
    .task_data   (task_data),
    .task_class  (task_class),
    .disp_valid  (disp_valid),
    .disp_data   (disp_data),
    .disp_ready  (disp_ready),
    .core_done   (core_done),
    .core_busy   (core_busy),
    .queue_level (queue_level),
    .load_level  (load_level),
    .fsm_state   (fsm_state)
  );

  // Driver tasks: all called and returning at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; task_valid = 1'b0; disp_ready = '0; core_done = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_task(input logic [TW-1:0] d, input logic c);
    task_valid = 1'b1; task_data = d; task_class = c;
    @(negedge clk);
    task_valid = 1'b0;
  endtask

  task automatic wait_offer(input int bound, output logic [NC-1:0] mask, output int waited);
    waited = 0;
    while (disp_valid == '0 && waited < bound) begin
      @(negedge clk);
      waited++;
    end
    mask = disp_valid;
  endtask

  task automatic handshake(input logic [NC-1:0] m);
    disp_ready = m;
    @(negedge clk);
    disp_ready = '0;
  endtask

  task automatic pulse_done(input logic [NC-1:0] m);
    core_done = m;
    @(negedge clk);
    core_done = '0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (disp_valid !== 4'b0000) begin failures++; $display("FAIL reset_disp_valid: got %b want 0000", disp_valid); end
    checks++; if (disp_data !== 32'h0) begin failures++; $display("FAIL reset_disp_data: got %h want 0", disp_data); end
    checks++; if (core_busy !== 4'b0000) begin failures++; $display("FAIL reset_core_busy: got %b want 0000", core_busy); end
    checks++; if (queue_level !== 4'd0) begin failures++; $display("FAIL reset_queue_level: got %0d want 0", queue_level); end
    checks++; if (load_level !== LOAD_IDLE) begin failures++; $display("FAIL reset_load_level: got %0d want 0", load_level); end
    checks++; if (task_ready !== 1'b1) begin failures++; $display("FAIL reset_task_ready: got %b want 1", task_ready); end
    checks++; if (fsm_state !== S_IDLE) begin failures++; $display("FAIL reset_fsm_state: got %0d want S_IDLE", fsm_state); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_dispatch();
    do_reset();
    push_task(32'hA5, CLS_SCALAR);
    checks++; if (queue_level !== 4'd1) begin failures++; $display("FAIL single_level_after_push: got %0d want 1", queue_level); end
    checks++; if (disp_valid !== 4'b0000) begin failures++; $display("FAIL single_no_early_offer: got %b want 0000", disp_valid); end
    @(negedge clk);
    checks++; if (disp_valid !== 4'b0000) begin failures++; $display("FAIL single_edge1_offer: got %b want 0000", disp_valid); end
    @(negedge clk);
    checks++; if (disp_valid !== 4'b0001) begin failures++; $display("FAIL single_edge2_offer: got %b want 0001", disp_valid); end
    checks++; if (disp_data !== 32'hA5) begin failures++; $display("FAIL single_disp_data: got %h want a5", disp_data); end
    handshake(4'b0001);
    checks++; if (core_busy !== 4'b0001) begin failures++; $display("FAIL single_core_busy: got %b want 0001", core_busy); end
    checks++; if (queue_level !== 4'd0) begin failures++; $display("FAIL single_level_after_pop: got %0d want 0", queue_level); end
    checks++; if (disp_valid !== 4'b0000) begin failures++; $display("FAIL single_offer_dropped: got %b want 0000", disp_valid); end
    @(negedge clk);
    checks++; if (load_level !== LOAD_LOW) begin failures++; $display("FAIL single_load_low: got %0d want 1", load_level); end
    pulse_done(4'b0001);
    checks++; if (core_busy !== 4'b0000) begin failures++; $display("FAIL single_done_clears: got %b want 0000", core_busy); end
    @(negedge clk);
    checks++; if (load_level !== LOAD_IDLE) begin failures++; $display("FAIL single_load_idle: got %0d want 0", load_level); end
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] m;
    logic [NC-1:0] exp_m;
    logic [TW-1:0] d;
    int w;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d = TW'(32'h100 + i);
      exp_m = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      push_task(d, CLS_SCALAR);
      wait_offer(10, m, w);
      checks++; if (m !== exp_m) begin failures++; $display("FAIL rr_target_%0d: got %b want %b", i, m, exp_m); end
      checks++; if (disp_data !== d) begin failures++; $display("FAIL rr_data_%0d: got %h want %h", i, disp_data, d); end
      handshake(m);
      pulse_done(m);
    end
  endtask

  task automatic test_full();
    logic [NC-1:0] m;
    logic [NC-1:0] one;
    logic [TW-1:0] exp_d;
    int w;
    one = 4'b0001;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      push_task(TW'(32'h300 + i), (i >= 2) ? CLS_VECTOR : CLS_SCALAR);
      wait_offer(10, m, w);
      checks++; if (m !== (one << i)) begin failures++; $display("FAIL full_fill_core_%0d: got %b want %b", i, m, one << i); end
      handshake(m);
    end
    checks++; if (core_busy !== 4'b1111) begin failures++; $display("FAIL full_all_busy: got %b want 1111", core_busy); end
    // Back-to-back pushes, one per cycle.
    for (int i = 0; i < DEPTH; i++) begin
      task_valid = 1'b1; task_class = CLS_SCALAR; task_data = TW'(32'h200 + i);
      exp_q.push_back(TW'(32'h200 + i));
      @(negedge clk);
      if (i == 3) begin
        checks++; if (load_level !== LOAD_LOW) begin failures++; $display("FAIL full_load_low: got %0d want 1", load_level); end
      end
      if (i == 4) begin
        checks++; if (load_level !== LOAD_MID) begin failures++; $display("FAIL full_load_mid: got %0d want 2", load_level); end
      end
    end
    task_data = 32'hDEAD;
    checks++; if (task_ready !== 1'b0) begin failures++; $display("FAIL full_task_ready: got %b want 0", task_ready); end
    checks++; if (queue_level !== 4'd8) begin failures++; $display("FAIL full_level: got %0d want 8", queue_level); end
    @(negedge clk);
    task_valid = 1'b0;
    checks++; if (queue_level !== 4'd8) begin failures++; $display("FAIL full_ninth_rejected: got %0d want 8", queue_level); end
    checks++; if (load_level !== LOAD_FULL) begin failures++; $display("FAIL full_load_full: got %0d want 3", load_level); end
    checks++; if (disp_valid !== 4'b0000) begin failures++; $display("FAIL full_no_offer: got %b want 0000", disp_valid); end
    // Drain through core 0 only, checking FIFO order against the expected queue.
    pulse_done(4'b0001);
    for (int i = 0; i < DEPTH; i++) begin
      wait_offer(10, m, w);
      exp_d = exp_q.pop_front();
      checks++; if (m !== 4'b0001) begin failures++; $display("FAIL drain_target_%0d: got %b want 0001", i, m); end
      checks++; if (disp_data !== exp_d) begin failures++; $display("FAIL drain_data_%0d: got %h want %h", i, disp_data, exp_d); end
      handshake(m);
      if (i == 0) begin
        checks++; if (queue_level !== 4'd7) begin failures++; $display("FAIL drain_level: got %0d want 7", queue_level); end
        checks++; if (task_ready !== 1'b1) begin failures++; $display("FAIL drain_task_ready: got %b want 1", task_ready); end
      end
      pulse_done(m);
    end
    checks++; if (queue_level !== 4'd0) begin failures++; $display("FAIL drain_empty: got %0d want 0", queue_level); end
  endtask

  task automatic test_hol_blocking();
    logic [NC-1:0] m;
    int w;
    do_reset();
    push_task(32'h401, CLS_VECTOR);
    wait_offer(10, m, w);
    checks++; if (m !== 4'b0100) begin failures++; $display("FAIL hol_fill_core2: got %b want 0100", m); end
    handshake(m);
    push_task(32'h402, CLS_VECTOR);
    wait_offer(10, m, w);
    checks++; if (m !== 4'b1000) begin failures++; $display("FAIL hol_fill_core3: got %b want 1000", m); end
    handshake(m);
    push_task(32'h77, CLS_VECTOR);
    push_task(32'h88, CLS_SCALAR);
`ifdef HTD_AGING_EN
    wait_offer(60, m, w);
    checks++; if (m !== 4'b0001) begin failures++; $display("FAIL aging_target: got %b want 0001", m); end
    checks++; if (disp_data !== 32'h77) begin failures++; $display("FAIL aging_data: got %h want 77", disp_data); end
    checks++; if (w !== AGE_LIMIT) begin failures++; $display("FAIL aging_delay: got %0d want %0d", w, AGE_LIMIT); end
`else
    repeat (20) @(negedge clk);
    checks++; if (disp_valid !== 4'b0000) begin failures++; $display("FAIL hol_blocked: got %b want 0000", disp_valid); end
    checks++; if (queue_level !== 4'd2) begin failures++; $display("FAIL hol_level: got %0d want 2", queue_level); end
    pulse_done(4'b0100);
    wait_offer(10, m, w);
    checks++; if (m !== 4'b0100) begin failures++; $display("FAIL hol_release_target: got %b want 0100", m); end
    checks++; if (disp_data !== 32'h77) begin failures++; $display("FAIL hol_release_data: got %h want 77", disp_data); end
`endif
  endtask

  task automatic test_offer_hold_and_reset();
    logic [NC-1:0] m;
    int w;
    do_reset();
    push_task(32'h5C, CLS_SCALAR);
    wait_offer(10, m, w);
    checks++; if (m !== 4'b0001) begin failures++; $display("FAIL hold_target: got %b want 0001", m); end
    for (int i = 0; i < 5; i++) begin
      disp_ready = 4'b0010;
      @(negedge clk);
      checks++; if (disp_valid !== 4'b0001) begin failures++; $display("FAIL hold_valid_%0d: got %b want 0001", i, disp_valid); end
      checks++; if (disp_data !== 32'h5C) begin failures++; $display("FAIL hold_data_%0d: got %h want 5c", i, disp_data); end
      checks++; if (queue_level !== 4'd1) begin failures++; $display("FAIL hold_level_%0d: got %0d want 1", i, queue_level); end
    end
    disp_ready = '0;
    checks++; if (core_busy !== 4'b0000) begin failures++; $display("FAIL hold_other_ignored: got %b want 0000", core_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (disp_valid !== 4'b0000) begin failures++; $display("FAIL midreset_valid: got %b want 0000", disp_valid); end
    checks++; if (queue_level !== 4'd0) begin failures++; $display("FAIL midreset_level: got %0d want 0", queue_level); end
    checks++; if (task_ready !== 1'b1) begin failures++; $display("FAIL midreset_task_ready: got %b want 1", task_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_done_idle_ignored();
    do_reset();
    pulse_done(4'b1111);
    checks++; if (core_busy !== 4'b0000) begin failures++; $display("FAIL idle_done_busy: got %b want 0000", core_busy); end
    @(negedge clk);
    checks++; if (load_level !== LOAD_IDLE) begin failures++; $display("FAIL idle_done_load: got %0d want 0", load_level); end
  endtask

  initial begin
    test_reset();
    test_single_dispatch();
    test_round_robin();
    test_full();
    test_hol_blocking();
    test_offer_hold_and_reset();
    test_done_idle_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
